mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, driving every datapath strobe: PC/IR enables, register-file and memory write enables, mux selects, ALU op and the immediate extender's sign/zero mode. It sits beside the datapath and sees only the IR opcode/funct fields, the ALU zero flag and the memory ready strobes.

## Interface
Parameters: none (all codes in package).
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag (A == B)
- imem_ready  in  1  instruction memory data valid (used only with wait feature)
- dmem_ready  in  1  data memory access complete (used only with wait feature)
- pc_we  out  1  PC write
- npc_sel  out  2  PC source: PLUS4 / BRANCH / JUMP / REG
- ir_we  out  1  IR write
- ext_mode  out  1  1 = sign-extend imm16, 0 = zero-extend
- alu_op  out  3  ADD / SUB / OR / LUI
- alu_src_b  out  1  0 = rt data, 1 = extended immediate
- mem_re  out  1  data memory read
- mem_we  out  1  data memory write
- reg_we  out  1  register file write
- reg_dst  out  2  RD / RT / RA(31)
- wd_sel  out  2  ALU / MEM / PC
- instr_done  out  1  one-cycle pulse in an instruction's final state

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Reset state FETCH.
- Supported: addu, subu (op 0, funct 0x21/0x23), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, jal 0x03, jr (op 0, funct 0x08). The all-zero word is nop. Any other encoding is treated as nop.
- FETCH: ir_we = 1, pc_we = 1, npc_sel = PLUS4 -> DECODE.
- DECODE:
  - jal: pc_we, npc_sel = JUMP, reg_we, reg_dst = RA, wd_sel = PC (the PC already holds old PC+4) -> FETCH.
  - jr: pc_we, npc_sel = REG -> FETCH.
  - nop or unknown -> FETCH.
  - All other instructions -> EXEC.
- EXEC:
  - addu/subu: alu_src_b = 0 -> WB.
  - ori: ext_mode = 0, alu_op = OR -> WB.
  - lui: ext_mode = 0, alu_op = LUI -> WB.
  - lw/sw: ext_mode = 1, alu_op = ADD, alu_src_b = 1 -> MEM.
  - beq: alu_op = SUB. If zero = 1: pc_we, npc_sel = BRANCH. -> FETCH.
- MEM:
  - lw: mem_re -> WB.
  - sw: mem_we -> FETCH.
- WB: reg_we, wd_sel = MEM for lw else ALU, reg_dst = RD for R-type else RT -> FETCH.
- Outputs are combinational from state plus op/funct/zero. Unasserted strobes are 0 and unused selects are 0.
- ext_mode is defined only in EXEC and is 0 in all other states.

## Timing
- While reset is low: state = FETCH and every enable (pc_we, ir_we, reg_we, mem_re, mem_we, instr_done) is forced to 0. Selects read 0.
- Asserting reset in any state aborts the instruction immediately, with no partial write after the assertion edge. The first FETCH occurs on the first rising edge after reset deasserts.
- Cycles per instruction (no waits): jal, jr, nop = 2; beq = 3; addu, subu, ori, lui, sw = 4; lw = 5.
- instr_done is high in exactly one cycle per instruction, coincident with that instruction's final strobe.
- op and funct must be stable from DECODE until the instruction completes. The IR updates only at the end of FETCH.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - FETCH holds while imem_ready = 0. ir_we and pc_we assert only in the cycle imem_ready = 1.
  - MEM holds while dmem_ready = 0. mem_re / mem_we stay asserted throughout the hold.
  - Each wait cycle adds one cycle to the instruction.
- Undefined: imem_ready and dmem_ready are ignored, and FETCH and MEM last exactly one cycle.

## Structure
- mc_ctrl_pkg holds:
  - state encoding;
  - opcode and funct constants;
  - alu_op codes;
  - npc_sel, reg_dst and wd_sel codes.
- Sub-module mc_decode: combinational classification of op/funct into one-hot instruction class (RTYPE_ALU, ORI, LUI, LW, SW, BEQ, JAL, JR, NOP).
- mc_ctrl holds the state register and the output logic.

## Test plan
- ori (op 0x0D) after reset: ir_we = 1 in cycle 1; EXEC in cycle 3 shows ext_mode = 0, alu_op = OR, alu_src_b = 1; cycle 4 shows reg_we = 1, reg_dst = RT, wd_sel = ALU, instr_done = 1.
- lw (op 0x23): ext_mode = 1 in EXEC; mem_re = 1 in cycle 4; reg_we = 1 with wd_sel = MEM in cycle 5; next cycle is FETCH.
- beq (op 0x04): with zero = 1, cycle 3 shows pc_we = 1, npc_sel = BRANCH. With zero = 0, pc_we = 0 in cycle 3. Both cases return to FETCH in cycle 4.
- jal (op 0x03): cycle 2 shows pc_we = 1, npc_sel = JUMP, reg_we = 1, reg_dst = RA, wd_sel = PC. jr (op 0, funct 0x08): cycle 2 shows npc_sel = REG.
- With MC_CTRL_MEM_WAIT_EN, lw with dmem_ready low for 3 cycles: mem_re is held for 4 cycles and the instruction completes in 8 cycles. Unknown op 0x3F: 2 cycles, with no reg_we or mem_we.
- reset driven low mid-MEM of sw: mem_we drops in the same cycle, no reg_we follows, and after release the first cycle is FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, opcode/funct constants and datapath select codes for mc_ctrl.
package mc_ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef struct packed {
        logic rtype;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic nop;
    } cls_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;
    localparam logic [1:0] DST_RD = 2'd0;
    localparam logic [1:0] DST_RT = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies op/funct into a one-hot instruction class; anything unsupported is nop.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);
    always_comb begin
        cls       = '0;
        cls.rtype = op == OP_RTYPE && (funct == FN_ADDU || funct == FN_SUBU);
        cls.jr    = op == OP_RTYPE && funct == FN_JR;
        cls.ori   = op == OP_ORI;
        cls.lui   = op == OP_LUI;
        cls.lw    = op == OP_LW;
        cls.sw    = op == OP_SW;
        cls.beq   = op == OP_BEQ;
        cls.jal   = op == OP_JAL;
        cls.nop   = !(cls.rtype | cls.jr | cls.ori | cls.lui | cls.lw | cls.sw | cls.beq | cls.jal);
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving all datapath strobes.
// Define MC_CTRL_MEM_WAIT_EN to stall FETCH on imem_ready and MEM on dmem_ready.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic       ir_we,
    output logic       ext_mode,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       instr_done
);
    state_t state, state_nx;
    cls_t   c;
    logic   iw, dw;

    mc_decode u_dec (.op(op), .funct(funct), .cls(c));

`ifdef MC_CTRL_MEM_WAIT_EN
    assign iw = imem_ready;
    assign dw = dmem_ready;
`else
    logic unused_ready;
    assign iw = 1'b1;
    assign dw = 1'b1;
    assign unused_ready = imem_ready ^ dmem_ready;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_FETCH;
        else        state <= state_nx;

    // Everything is gated by reset so an assertion cuts strobes in the same cycle.
    always_comb begin
        state_nx   = state;
        pc_we      = 1'b0;
        npc_sel    = NPC_PLUS4;
        ir_we      = 1'b0;
        ext_mode   = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RD;
        wd_sel     = WD_ALU;
        instr_done = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    ir_we    = iw;
                    pc_we    = iw;
                    state_nx = iw ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    pc_we      = c.jal | c.jr;
                    npc_sel    = c.jal ? NPC_JUMP : c.jr ? NPC_REG : NPC_PLUS4;
                    reg_we     = c.jal;
                    reg_dst    = c.jal ? DST_RA : DST_RD;
                    wd_sel     = c.jal ? WD_PC : WD_ALU;
                    instr_done = c.jal | c.jr | c.nop;
                    state_nx   = instr_done ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    ext_mode   = c.lw | c.sw;
                    alu_op     = c.ori ? ALU_OR : c.lui ? ALU_LUI :
                                 (c.beq || (c.rtype && funct == FN_SUBU)) ? ALU_SUB : ALU_ADD;
                    alu_src_b  = c.ori | c.lui | c.lw | c.sw;
                    pc_we      = c.beq & zero;
                    npc_sel    = (c.beq && zero) ? NPC_BRANCH : NPC_PLUS4;
                    instr_done = c.beq;
                    state_nx   = c.beq ? S_FETCH : (c.lw || c.sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    mem_re     = c.lw;
                    mem_we     = c.sw;
                    instr_done = c.sw & dw;
                    state_nx   = !dw ? S_MEM : c.sw ? S_FETCH : S_WB;
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    wd_sel     = c.lw ? WD_MEM : WD_ALU;
                    reg_dst    = c.rtype ? DST_RD : DST_RT;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-instruction cycle checks of mc_ctrl strobes against hand-computed vectors.
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b1;
    logic       dmem_ready = 1'b1;
    logic       pc_we, ir_we, ext_mode, alu_src_b, mem_re, mem_we, reg_we, instr_done;
    logic [1:0] npc_sel, reg_dst, wd_sel;
    logic [2:0] alu_op;
    logic [16:0] outs, e;
    int checks = 0;
    int fails = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .ext_mode(ext_mode),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, npc_sel, ir_we, ext_mode, alu_op, alu_src_b, mem_re, mem_we,
                   reg_we, reg_dst, wd_sel, instr_done};

    // npc: 0 PLUS4 1 BRANCH 2 JUMP 3 REG; alu: 0 ADD 1 SUB 2 OR 3 LUI; dst: 0 RD 1 RT 2 RA; wd: 0 ALU 1 MEM 2 PC
    function automatic logic [16:0] pk(input logic pc, input logic [1:0] npc, input logic ir,
                                       input logic ext, input logic [2:0] alu, input logic srcb,
                                       input logic re, input logic we, input logic rw,
                                       input logic [1:0] dst, input logic [1:0] wd, input logic done);
        return {pc, npc, ir, ext, alu, srcb, re, we, rw, dst, wd, done};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        op = 6'h03;
        tick; tick;
        checks++; if (outs !== 17'h0) begin $display("FAIL reset_hold got=%h exp=%h", outs, 17'h0); fails++; end
        @(posedge clk); #1; reset = 1'b1; op = 6'h00; #1;
        e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL reset_first_fetch got=%h exp=%h", outs, e); fails++; end
    endtask

    task automatic test_ori;
        op = 6'h0D; funct = 6'h00; #1;
        e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL ori_c1 got=%h exp=%h", outs, e); fails++; end
        tick;
        checks++; if (outs !== 17'h0) begin $display("FAIL ori_c2 got=%h exp=%h", outs, 17'h0); fails++; end
        tick; e = pk(0,0,0,0,2,1,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL ori_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(0,0,0,0,0,0,0,0,1,1,0,1);
        checks++; if (outs !== e) begin $display("FAIL ori_c4 got=%h exp=%h", outs, e); fails++; end
        tick;
    endtask

    task automatic test_lw;
        op = 6'h23; #1;
        tick; tick; e = pk(0,0,0,1,0,1,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL lw_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(0,0,0,0,0,0,1,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL lw_c4 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(0,0,0,0,0,0,0,0,1,1,1,1);
        checks++; if (outs !== e) begin $display("FAIL lw_c5 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL lw_next_fetch got=%h exp=%h", outs, e); fails++; end
    endtask

    task automatic test_sw;
        op = 6'h2B; #1;
        tick; tick; e = pk(0,0,0,1,0,1,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL sw_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(0,0,0,0,0,0,0,1,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL sw_c4 got=%h exp=%h", outs, e); fails++; end
        tick;
    endtask

    task automatic test_rtype;
        op = 6'h00; funct = 6'h21; #1;
        tick; tick;
        checks++; if (outs !== 17'h0) begin $display("FAIL addu_c3 got=%h exp=%h", outs, 17'h0); fails++; end
        tick; e = pk(0,0,0,0,0,0,0,0,1,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL addu_c4 got=%h exp=%h", outs, e); fails++; end
        tick; funct = 6'h23; #1;
        tick; tick; e = pk(0,0,0,0,1,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL subu_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(0,0,0,0,0,0,0,0,1,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL subu_c4 got=%h exp=%h", outs, e); fails++; end
        tick; op = 6'h0F; funct = 6'h00; #1;
        tick; tick; e = pk(0,0,0,0,3,1,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL lui_c3 got=%h exp=%h", outs, e); fails++; end
        tick; tick;
    endtask

    task automatic test_beq;
        op = 6'h04; zero = 1'b1; #1;
        tick; tick; e = pk(1,1,0,0,1,0,0,0,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL beq_taken_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL beq_taken_c4 got=%h exp=%h", outs, e); fails++; end
        zero = 1'b0; #1;
        tick; tick; e = pk(0,0,0,0,1,0,0,0,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL beq_not_taken_c3 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL beq_not_taken_c4 got=%h exp=%h", outs, e); fails++; end
    endtask

    task automatic test_jump;
        op = 6'h03; #1;
        tick; e = pk(1,2,0,0,0,0,0,0,1,2,2,1);
        checks++; if (outs !== e) begin $display("FAIL jal_c2 got=%h exp=%h", outs, e); fails++; end
        tick; op = 6'h00; funct = 6'h08; #1;
        tick; e = pk(1,3,0,0,0,0,0,0,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL jr_c2 got=%h exp=%h", outs, e); fails++; end
        tick; e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL jr_next_fetch got=%h exp=%h", outs, e); fails++; end
    endtask

    task automatic test_nop;
        op = 6'h3F; funct = 6'h00; #1;
        tick; e = pk(0,0,0,0,0,0,0,0,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL unknown_c2 got=%h exp=%h", outs, e); fails++; end
        tick; op = 6'h00; #1;
        checks++; if (outs !== pk(1,0,1,0,0,0,0,0,0,0,0,0)) begin $display("FAIL unknown_c3_fetch got=%h", outs); fails++; end
        tick;
        checks++; if (outs !== e) begin $display("FAIL zero_word_c2 got=%h exp=%h", outs, e); fails++; end
        tick;
    endtask

    task automatic test_wait;
`ifdef MC_CTRL_MEM_WAIT_EN
        imem_ready = 1'b0; op = 6'h23; #1;
        checks++; if (outs !== 17'h0) begin $display("FAIL imem_wait got=%h exp=%h", outs, 17'h0); fails++; end
        tick; imem_ready = 1'b1; #1;
        e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL imem_ready_fetch got=%h exp=%h", outs, e); fails++; end
        tick; tick; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i == 3) begin dmem_ready = 1'b1; #1; end
            e = pk(0,0,0,0,0,0,1,0,0,0,0,0);
            checks++; if (outs !== e) begin $display("FAIL lw_wait_mem%0d got=%h exp=%h", i, outs, e); fails++; end
        end
        tick; e = pk(0,0,0,0,0,0,0,0,1,1,1,1);
        checks++; if (outs !== e) begin $display("FAIL lw_wait_c8 got=%h exp=%h", outs, e); fails++; end
        tick;
`else
        imem_ready = 1'b0; dmem_ready = 1'b0; op = 6'h2B; #1;
        e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL imem_ignored got=%h exp=%h", outs, e); fails++; end
        tick; tick; tick; e = pk(0,0,0,0,0,0,0,1,0,0,0,1);
        checks++; if (outs !== e) begin $display("FAIL dmem_ignored got=%h exp=%h", outs, e); fails++; end
        tick; imem_ready = 1'b1; dmem_ready = 1'b1;
`endif
    endtask

    task automatic test_reset_mid_sw;
        op = 6'h2B; #1;
        tick; tick; tick;
        reset = 1'b0; #1;
        checks++; if (outs !== 17'h0) begin $display("FAIL sw_abort_mem_we got=%h exp=%h", outs, 17'h0); fails++; end
        tick; tick;
        checks++; if (outs !== 17'h0) begin $display("FAIL sw_abort_no_reg_we got=%h exp=%h", outs, 17'h0); fails++; end
        reset = 1'b1; #1;
        e = pk(1,0,1,0,0,0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin $display("FAIL sw_abort_refetch got=%h exp=%h", outs, e); fails++; end
        tick;
        checks++; if (outs !== 17'h0) begin $display("FAIL sw_abort_decode got=%h exp=%h", outs, 17'h0); fails++; end
    endtask

    initial begin
        test_reset;
        test_ori;
        test_lw;
        test_sw;
        test_rtype;
        test_beq;
        test_jump;
        test_nop;
        test_wait;
        test_reset_mid_sw;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
